// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared state encoding and width helpers for the CSA accumulator
package csa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MAX_OPS = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int sum_width(input int width, input int max_ops);
        return width + clog2(max_ops);
    endfunction

    function automatic int cnt_width(input int max_ops);
        return clog2(max_ops) + 1;
    endfunction

endpackage

// File: rtl/csa_row.sv
// rtl/csa_row.sv - OW-bit 3:2 carry-save compressor row
module csa_row
    import csa_pkg::*;
#(
    parameter int OW = sum_width(DEF_WIDTH, DEF_MAX_OPS)
)(
    input  logic [OW-1:0] a,
    input  logic [OW-1:0] b,
    input  logic [OW-1:0] d,
    output logic [OW-1:0] sum,
    output logic [OW-1:0] carry
);

    assign sum = a ^ b ^ d;

    // Carry is returned already at weight 2; the bit shifted past OW is dropped (mod 2^OW).
    assign carry = {(a[OW-2:0] & b[OW-2:0]) |
                    (a[OW-2:0] & d[OW-2:0]) |
                    (b[OW-2:0] & d[OW-2:0]), 1'b0};

endmodule

// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - streaming group summer: carry-save accumulate, resolve, hand off
module csa_accum_ctrl
    import csa_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_OPS = DEF_MAX_OPS,
    localparam int OW     = sum_width(WIDTH, MAX_OPS),
    localparam int CW     = cnt_width(MAX_OPS)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_sum,
    output logic [CW-1:0]    out_count,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OPS);

    state_t          state;
    logic [OW-1:0]   s_q;
    logic [OW-1:0]   cs_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;
    logic [OW-1:0]   res_sum_q;
    logic [CW-1:0]   res_cnt_q;
    logic            res_ovf_q;
    logic [OW-1:0]   d_ext;
    logic [OW-1:0]   row_sum;
    logic [OW-1:0]   row_carry;
    logic            accept;

    assign d_ext = {{(OW-WIDTH){1'b0}}, in_data};

    // cs_q holds the carry vector pre-shifted, so S + cs_q is the running total.
    csa_row #(.OW(OW)) u_row (
        .a     (s_q),
        .b     (cs_q),
        .d     (d_ext),
        .sum   (row_sum),
        .carry (row_carry)
    );

    assign in_ready  = !rst && (state == ST_IDLE || state == ST_ACCUM);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_OUTPUT);
    assign busy      = (state != ST_IDLE);
    assign out_sum   = res_sum_q;
    assign out_count = res_cnt_q;
    assign out_ovf   = res_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            s_q       <= '0;
            cs_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_sum_q <= '0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        s_q   <= d_ext;
                        cs_q  <= '0;
                        cnt_q <= CW'(1);
                        ovf_q <= 1'b0;
                        state <= in_last ? ST_RESOLVE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        if (cnt_q < CNT_MAX) begin
                            s_q   <= row_sum;
                            cs_q  <= row_carry;
                            cnt_q <= cnt_q + CW'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                        if (in_last) begin
                            state <= ST_RESOLVE;
                        end
                    end
                end
                ST_RESOLVE: begin
                    res_sum_q <= s_q + cs_q;
                    res_cnt_q <= cnt_q;
                    res_ovf_q <= ovf_q;
                    state     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb/tb_csa_accum_ctrl.sv - self-checking bench for csa_accum_ctrl
module tb_csa_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [4:0]  out_count;
    logic        out_ovf;
    logic        busy;

    always #5 clk = ~clk;

    csa_accum_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    typedef struct packed {
        logic [11:0] sum;
        logic [4:0]  cnt;
        logic        ovf;
    } res_t;

    typedef struct {
        int               n;
        logic [19:0][7:0] ops;
        bit               gaps;
        res_t             exp;
    } vec_t;

    localparam int NVEC = 8;

    vec_t vecs [NVEC];
    res_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #3;
        chk("in_ready_beat", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic gap_cycles(input int k);
        out_ready = 1'b1;
        for (int g = 0; g < k; g++) begin
            tick();
            chk("gap_busy", 32'(busy), 1);
            chk("gap_in_ready", 32'(in_ready), 1);
            chk("gap_out_valid", 32'(out_valid), 0);
        end
        out_ready = 1'b0;
    endtask

    task automatic send_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            if (v.gaps && i > 0) gap_cycles(int'($urandom_range(1, 3)));
            beat(v.ops[i], (i == v.n - 1));
        end
        sb.push_back(v.exp);
        chk("resolve_out_valid", 32'(out_valid), 0);
        chk("resolve_in_ready", 32'(in_ready), 0);
        chk("resolve_busy", 32'(busy), 1);
        tick();
        chk("latency_out_valid", 32'(out_valid), 1);
    endtask

    task automatic collect(input int hold);
        res_t e;
        int   k;
        k = 0;
        out_ready = 1'b0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: out_valid never rose, got 0 expected 1");
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got sum %0d expected no result", out_sum);
        end else begin
            e = sb.pop_front();
            in_valid = (hold > 0);
            in_data  = 8'hAA;
            in_last  = 1'b1;
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("hold_out_valid", 32'(out_valid), 1);
                chk("hold_out_sum", 32'(out_sum), 32'(e.sum));
                chk("hold_in_ready", 32'(in_ready), 0);
            end
            chk("out_sum", 32'(out_sum), 32'(e.sum));
            chk("out_count", 32'(out_count), 32'(e.cnt));
            chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
            in_valid  = 1'b0;
            in_last   = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("post_busy", 32'(busy), 0);
            chk("post_in_ready", 32'(in_ready), 1);
            chk("post_out_valid", 32'(out_valid), 0);
        end
    endtask

    function automatic vec_t mk(input int n, input bit gaps, input int s, input int c, input bit o);
        vec_t v;
        v.n       = n;
        v.ops     = '0;
        v.gaps    = gaps;
        v.exp.sum = 12'(s);
        v.exp.cnt = 5'(c);
        v.exp.ovf = o;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(3, 1'b0, 355, 3, 1'b0);
        vecs[0].ops[0] = 8'd200; vecs[0].ops[1] = 8'd100; vecs[0].ops[2] = 8'd55;
        vecs[1] = mk(1, 1'b0, 255, 1, 1'b0);
        vecs[1].ops[0] = 8'hFF;
        vecs[2] = mk(17, 1'b0, 4080, 16, 1'b1);
        for (int i = 0; i < 17; i++) vecs[2].ops[i] = 8'hFF;
        vecs[3] = mk(3, 1'b1, 60, 3, 1'b0);
        vecs[3].ops[0] = 8'd10; vecs[3].ops[1] = 8'd20; vecs[3].ops[2] = 8'd30;
        vecs[4] = mk(16, 1'b0, 4080, 16, 1'b0);
        for (int i = 0; i < 16; i++) vecs[4].ops[i] = 8'hFF;
        vecs[5] = mk(1, 1'b0, 0, 1, 1'b0);
        vecs[6] = mk(20, 1'b1, 16, 16, 1'b1);
        for (int i = 0; i < 20; i++) vecs[6].ops[i] = 8'd1;
        vecs[7] = mk(5, 1'b0, 15, 5, 1'b0);
        for (int i = 0; i < 5; i++) vecs[7].ops[i] = 8'(i + 1);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_out_ovf", 32'(out_ovf), 0);
        rst = 1'b0;
        #3;
        chk("rst_release_in_ready", 32'(in_ready), 1);

        for (int i = 0; i < NVEC; i++) begin
            send_vec(vecs[i]);
            collect((i == 3) ? 5 : 0);
        end

        // Reset while the result is waiting in OUTPUT: it must vanish.
        beat(8'd5, 1'b1);
        tick();
        chk("pend_out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        chk("pend_rst_out_valid", 32'(out_valid), 0);
        chk("pend_rst_busy", 32'(busy), 0);
        chk("pend_rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #3;
        chk("pend_release_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pend_no_output", 32'(out_valid), 0);
        end

        // Reset mid-group, then a fresh two-beat group.
        beat(8'd9, 1'b0);
        beat(8'd9, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        beat(8'd1, 1'b0);
        beat(8'd2, 1'b1);
        sb.push_back('{sum: 12'd3, cnt: 5'd2, ovf: 1'b0});
        collect(0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_extra_output", 32'(out_valid), 0);
        end

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
